commit_trace_buffer: RTL and testbench

//  Parametrised successor to the per-cycle GPR/PC trace tap. Accepts up to NCOMMIT retired-instruction

---
 rtl/commit_trace_if.sv | 33 +++
 rtl/commit_trace_buffer.sv | 116 +++++++++++
 tb/tb_commit_trace_buffer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_if.sv
// Commit-to-trace bundle: retired-record lanes in, one head record out over valid/ready.
// master drives records and out_ready; slave is the trace buffer.
interface commit_trace_if #(
  parameter int XLEN    = 64,
  parameter int NCOMMIT = 2
);
  logic [NCOMMIT-1:0]      in_valid;
  logic [NCOMMIT*XLEN-1:0] in_pc;
  logic [NCOMMIT*32-1:0]   in_inst;
  logic [NCOMMIT*5-1:0]    in_rd;
  logic [NCOMMIT-1:0]      in_wen;
  logic [NCOMMIT*XLEN-1:0] in_wdata;
  logic                    in_ready;

  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         out_pc;
  logic [31:0]             out_inst;
  logic [4:0]              out_rd;
  logic                    out_wen;
  logic [XLEN-1:0]         out_wdata;
  logic [63:0]             out_seq;

  modport master (
    output in_valid, in_pc, in_inst, in_rd, in_wen, in_wdata, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_rd, out_wen, out_wdata, out_seq
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_rd, in_wen, in_wdata, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_rd, out_wen, out_wdata, out_seq
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Multi-lane retired-instruction trace FIFO with shadow GPR file and stall/drop overflow modes.
// Valid lanes are compacted into consecutive slots; records leave one per cycle over valid/ready.
module commit_trace_buffer #(
  parameter int XLEN    = 64,
  parameter int NCOMMIT = 2,
  parameter int DEPTH   = 16,
  parameter int DROP    = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  commit_trace_if.slave          bus,
  output logic [32*XLEN-1:0]     shadow_gpr,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [31:0]            drop_cnt
);
  // DEPTH must be a power of two >= 2 so pointers wrap naturally.
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [4:0]      rd;
    logic            wen;
    logic [XLEN-1:0] wdata;
  } rec_t;

  rec_t               mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [63:0]        seq;
  logic [LW-1:0]      free;
  logic [LW-1:0]      n_acc;
  logic [31:0]        n_drop;
  logic [NCOMMIT-1:0] lane_acc;
  logic [PW-1:0]      lane_slot [NCOMMIT];
  logic               in_ready;
  logic               fire;
  rec_t               head;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hffff_ffff : s[31:0];
  endfunction

  // Ready depends on registered level only, never on out_ready.
  assign free     = LW'(DEPTH) - level;
  assign in_ready = (DROP != 0) ? 1'b1 : (free >= LW'(NCOMMIT));
  assign head     = mem[rd_ptr];
  assign fire     = (level != '0) && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (level != '0);
  assign bus.out_pc    = head.pc;
  assign bus.out_inst  = head.inst;
  assign bus.out_rd    = head.rd;
  assign bus.out_wen   = head.wen;
  assign bus.out_wdata = head.wdata;
  assign bus.out_seq   = seq;

  // Lane compaction: each accepted lane lands at wr_ptr + (accepted lanes below it).
  always_comb begin
    n_acc    = '0;
    n_drop   = '0;
    lane_acc = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      lane_slot[i] = wr_ptr + PW'(n_acc);
      if (bus.in_valid[i] && in_ready) begin
        if (n_acc < free) begin
          lane_acc[i] = 1'b1;
          n_acc       = n_acc + LW'(1);
        end else begin
          n_drop = n_drop + 32'd1;
        end
      end
    end
  end

  // Control state and architectural shadow
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      seq        <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      shadow_gpr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_acc);
      level  <= level + n_acc - LW'(fire);
      if (fire) begin
        rd_ptr <= rd_ptr + PW'(1);
        seq    <= seq + 64'd1;
        if (head.wen && (head.rd != 5'd0))
          shadow_gpr[int'(head.rd)*XLEN +: XLEN] <= head.wdata;
      end
      if (n_drop != '0) begin
        overflow <= 1'b1;
        drop_cnt <= sat_add32(drop_cnt, n_drop);
      end
    end
  end

  // Record storage
  always_ff @(posedge clock) begin
    for (int i = 0; i < NCOMMIT; i++) begin
      if (lane_acc[i])
        mem[lane_slot[i]] <= {bus.in_pc[i*XLEN +: XLEN], bus.in_inst[i*32 +: 32],
                              bus.in_rd[i*5 +: 5], bus.in_wen[i],
                              bus.in_wdata[i*XLEN +: XLEN]};
    end
  end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Drives a stall-mode and a drop-mode buffer with identical stimulus and checks both
// against a queue-based reference model of the retire trace.
module tb_commit_trace_buffer;
  localparam int XLEN  = 64;
  localparam int NC    = 2;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] wdata;
  } rec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  commit_trace_if #(.XLEN(XLEN), .NCOMMIT(NC)) bus_a ();
  commit_trace_if #(.XLEN(XLEN), .NCOMMIT(NC)) bus_b ();

  logic [32*XLEN-1:0] shadow_a, shadow_b;
  logic [4:0]         level_a, level_b;
  logic               ovf_a, ovf_b;
  logic [31:0]        dcnt_a, dcnt_b;

  commit_trace_buffer #(.XLEN(XLEN), .NCOMMIT(NC), .DEPTH(DEPTH), .DROP(0)) u_stall (
    .clock(clock), .reset(reset), .bus(bus_a.slave),
    .shadow_gpr(shadow_a), .level(level_a), .overflow(ovf_a), .drop_cnt(dcnt_a));

  commit_trace_buffer #(.XLEN(XLEN), .NCOMMIT(NC), .DEPTH(DEPTH), .DROP(1)) u_drop (
    .clock(clock), .reset(reset), .bus(bus_b.slave),
    .shadow_gpr(shadow_b), .level(level_b), .overflow(ovf_b), .drop_cnt(dcnt_b));

  // Reference model, index 0 = stall instance, 1 = drop instance
  rec_t        mq [2][$];
  logic [63:0] mseq [2];
  logic [63:0] mgpr [2][32];
  logic [31:0] mdrop [2];
  logic        movf [2];
  bit          mvalid = 0;

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic rec_t rnd_rec();
    rec_t r;
    r.pc    = {$urandom, $urandom};
    r.inst  = $urandom;
    r.rd    = 5'($urandom_range(0, 31));
    r.wen   = 1'($urandom_range(0, 1));
    r.wdata = {$urandom, $urandom};
    return r;
  endfunction

  function automatic rec_t mk(input logic [63:0] pc, input logic [4:0] rd,
                              input logic wen, input logic [63:0] wdata);
    rec_t r;
    r.pc = pc; r.inst = 32'h0000_0013; r.rd = rd; r.wen = wen; r.wdata = wdata;
    return r;
  endfunction

  task automatic check_dut(input int k);
    logic        ov, ir, ovf;
    logic [63:0] pc, wd, sq;
    logic [31:0] inst, dc;
    logic [4:0]  rd, lv;
    logic        wen;
    logic [32*XLEN-1:0] sh;
    int free;
    if (k == 0) begin
      ov = bus_a.out_valid; ir = bus_a.in_ready; pc = bus_a.out_pc; inst = bus_a.out_inst;
      rd = bus_a.out_rd; wen = bus_a.out_wen; wd = bus_a.out_wdata; sq = bus_a.out_seq;
      lv = level_a; ovf = ovf_a; dc = dcnt_a; sh = shadow_a;
    end else begin
      ov = bus_b.out_valid; ir = bus_b.in_ready; pc = bus_b.out_pc; inst = bus_b.out_inst;
      rd = bus_b.out_rd; wen = bus_b.out_wen; wd = bus_b.out_wdata; sq = bus_b.out_seq;
      lv = level_b; ovf = ovf_b; dc = dcnt_b; sh = shadow_b;
    end
    free = DEPTH - mq[k].size();
    chk($sformatf("level%0d", k), 64'(lv), 64'(mq[k].size()));
    chk($sformatf("in_ready%0d", k), 64'(ir), 64'((k == 1) || (free >= NC)));
    chk($sformatf("out_valid%0d", k), 64'(ov), 64'(mq[k].size() != 0));
    chk($sformatf("out_seq%0d", k), sq, mseq[k]);
    chk($sformatf("overflow%0d", k), 64'(ovf), 64'(movf[k]));
    chk($sformatf("drop_cnt%0d", k), 64'(dc), 64'(mdrop[k]));
    if (mq[k].size() != 0) begin
      chk($sformatf("out_pc%0d", k), pc, mq[k][0].pc);
      chk($sformatf("out_inst%0d", k), 64'(inst), 64'(mq[k][0].inst));
      chk($sformatf("out_rd%0d", k), 64'(rd), 64'(mq[k][0].rd));
      chk($sformatf("out_wen%0d", k), 64'(wen), 64'(mq[k][0].wen));
      chk($sformatf("out_wdata%0d", k), wd, mq[k][0].wdata);
    end
    for (int r = 0; r < 32; r++)
      chk($sformatf("gpr%0d_x%0d", k, r), sh[r*XLEN +: XLEN], mgpr[k][r]);
  endtask

  task automatic step(input int k, input logic rst, input logic [1:0] v,
                      input rec_t r0, input rec_t r1, input logic ordy);
    int   free, taken;
    bit   rdy, fire;
    rec_t hd;
    rec_t lanes [2];
    if (rst) begin
      mq[k].delete();
      mseq[k] = '0; mdrop[k] = '0; movf[k] = 1'b0;
      for (int r = 0; r < 32; r++) mgpr[k][r] = '0;
      return;
    end
    lanes[0] = r0; lanes[1] = r1;
    free  = DEPTH - mq[k].size();
    rdy   = (k == 1) || (free >= NC);
    fire  = (mq[k].size() != 0) && ordy;
    taken = 0;
    if (fire) hd = mq[k][0];
    if (rdy) begin
      for (int i = 0; i < NC; i++) begin
        if (v[i]) begin
          if (taken < free) begin
            mq[k].push_back(lanes[i]);
            taken++;
          end else begin
            movf[k] = 1'b1;
            if (mdrop[k] != 32'hffff_ffff) mdrop[k] = mdrop[k] + 1;
          end
        end
      end
    end
    if (fire) begin
      void'(mq[k].pop_front());
      mseq[k] = mseq[k] + 1;
      if (hd.wen && hd.rd != 0) mgpr[k][hd.rd] = hd.wdata;
    end
  endtask

  task automatic cyc(input logic rst, input logic [1:0] v, input rec_t r0, input rec_t r1,
                     input logic ordy);
    reset = rst;
    bus_a.in_valid = v;                  bus_b.in_valid = v;
    bus_a.in_pc    = {r1.pc, r0.pc};     bus_b.in_pc    = {r1.pc, r0.pc};
    bus_a.in_inst  = {r1.inst, r0.inst}; bus_b.in_inst  = {r1.inst, r0.inst};
    bus_a.in_rd    = {r1.rd, r0.rd};     bus_b.in_rd    = {r1.rd, r0.rd};
    bus_a.in_wen   = {r1.wen, r0.wen};   bus_b.in_wen   = {r1.wen, r0.wen};
    bus_a.in_wdata = {r1.wdata, r0.wdata}; bus_b.in_wdata = {r1.wdata, r0.wdata};
    bus_a.out_ready = ordy;              bus_b.out_ready = ordy;
    @(negedge clock);
    if (mvalid) begin
      check_dut(0);
      check_dut(1);
    end
    @(posedge clock);
    step(0, rst, v, r0, r1, ordy);
    step(1, rst, v, r0, r1, ordy);
    if (rst) mvalid = 1;
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, rnd_rec(), rnd_rec(), ordy);
  endtask

  initial begin
    rec_t z;
    z = mk(64'h0, 5'd0, 1'b0, 64'h0);

    // Reset held two cycles
    cyc(1'b1, 2'b11, rnd_rec(), rnd_rec(), 1'b1);
    cyc(1'b1, 2'b00, z, z, 1'b1);
    chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
    chk("rst_level", 64'(level_a), 64'd0);
    chk("rst_seq", bus_a.out_seq, 64'd0);
    chk("rst_shadow_x5", shadow_a[5*XLEN +: XLEN], 64'd0);

    // Ordering: both lanes write x5
    cyc(1'b0, 2'b11, mk(64'h8000_0000, 5'd5, 1'b1, 64'h11),
                     mk(64'h8000_0004, 5'd5, 1'b1, 64'h22), 1'b1);
    chk("ord_head_pc", bus_a.out_pc, 64'h8000_0000);
    chk("ord_head_seq", bus_a.out_seq, 64'd0);
    cyc(1'b0, 2'b00, z, z, 1'b1);
    chk("ord_x5_first", shadow_a[5*XLEN +: XLEN], 64'h11);
    chk("ord_seq1", bus_a.out_seq, 64'd1);
    cyc(1'b0, 2'b00, z, z, 1'b1);
    chk("ord_x5_second", shadow_a[5*XLEN +: XLEN], 64'h22);

    // Compaction: only lane 1 valid
    cyc(1'b0, 2'b10, rnd_rec(), mk(64'h8000_0008, 5'd6, 1'b1, 64'h33), 1'b1);
    chk("cmp_level", 64'(level_a), 64'd1);
    chk("cmp_pc", bus_a.out_pc, 64'h8000_0008);
    chk("cmp_seq", bus_a.out_seq, 64'd2);
    idle(2, 1'b1);

    // x0 guard
    cyc(1'b0, 2'b01, mk(64'h8000_000c, 5'd0, 1'b1, 64'hdead), z, 1'b1);
    idle(2, 1'b1);
    chk("x0_zero", shadow_a[0 +: XLEN], 64'd0);

    // Backpressure fill
    for (int i = 0; i < 8; i++) cyc(1'b0, 2'b11, rnd_rec(), rnd_rec(), 1'b0);
    chk("bp_level16", 64'(level_a), 64'd16);
    chk("bp_not_ready", 64'(bus_a.in_ready), 64'd0);
    cyc(1'b0, 2'b00, z, z, 1'b1);
    chk("bp_level15", 64'(level_a), 64'd15);
    chk("bp_still_not_ready", 64'(bus_a.in_ready), 64'd0);

    // Drop mode at level 15 then full
    cyc(1'b0, 2'b11, rnd_rec(), rnd_rec(), 1'b0);
    chk("drop_level16", 64'(level_b), 64'd16);
    chk("drop_ovf", 64'(ovf_b), 64'd1);
    chk("drop_cnt1", 64'(dcnt_b), 64'd1);
    chk("stall_ignored", 64'(level_a), 64'd15);
    cyc(1'b0, 2'b11, rnd_rec(), rnd_rec(), 1'b0);
    chk("drop_cnt3", 64'(dcnt_b), 64'd3);
    cyc(1'b0, 2'b00, z, z, 1'b1);
    chk("bp_level14", 64'(level_a), 64'd14);
    chk("bp_ready_again", 64'(bus_a.in_ready), 64'd1);
    chk("stall_no_ovf", 64'(ovf_a), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 200; i++)
      cyc(1'b0, 2'($urandom_range(0, 3)), rnd_rec(), rnd_rec(), ($urandom_range(0, 3) != 0));
    idle(20, 1'b1);

    // Mid-operation reset at level 5
    cyc(1'b0, 2'b11, rnd_rec(), rnd_rec(), 1'b0);
    cyc(1'b0, 2'b11, rnd_rec(), rnd_rec(), 1'b0);
    cyc(1'b0, 2'b01, rnd_rec(), rnd_rec(), 1'b0);
    chk("mid_level5", 64'(level_a), 64'd5);
    cyc(1'b1, 2'b11, rnd_rec(), rnd_rec(), 1'b1);
    chk("mid_level0", 64'(level_a), 64'd0);
    chk("mid_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("mid_drop_cleared", 64'(dcnt_b), 64'd0);
    cyc(1'b0, 2'b01, mk(64'h8000_0100, 5'd7, 1'b1, 64'h77), z, 1'b1);
    chk("mid_seq0", bus_a.out_seq, 64'd0);
    chk("mid_valid", 64'(bus_a.out_valid), 64'd1);
    idle(3, 1'b1);
    chk("mid_x7", shadow_a[7*XLEN +: XLEN], 64'h77);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
